// File: rtl/fpga_rst_pkg.sv
// Shared types and constants for the multi-PLL reset sequencer.
package fpga_rst_pkg;

    localparam int unsigned SYNC_STAGES_MIN = 2;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } rst_state_t;

endpackage

// File: rtl/fpga_sync_bit.sv
// N-stage single-bit synchroniser with asynchronous active-low clear.
module fpga_sync_bit #(
    parameter int unsigned STAGES = 3
) (
    input  logic clk,
    input  logic arst_n,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fpga_rst_seq.sv
// Reset sequencer: qualifies synchronised PLL locks, then releases domain
// resets in a staggered order; any lock loss or sw request drops them all.
module fpga_rst_seq
    import fpga_rst_pkg::*;
#(
    parameter int unsigned NUM_LOCK    = 2,
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned STABLE_CYC  = 1024,
    parameter int unsigned NUM_DOMAINS = 3,
    parameter int unsigned GAP_CYC     = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [NUM_LOCK-1:0]    lock_i,
    input  logic [NUM_LOCK-1:0]    lock_mask,
    input  logic                   sw_rst,
    input  logic                   loss_cnt_clr,
    output logic [NUM_DOMAINS-1:0] srst_n,
    output logic                   all_rdy,
    output logic [1:0]             state_o,
    output logic [CNT_W-1:0]       loss_cnt
);

    localparam int unsigned CNT_BITS = (STABLE_CYC  > 1) ? $clog2(STABLE_CYC)  : 1;
    localparam int unsigned GAP_BITS = (GAP_CYC     > 1) ? $clog2(GAP_CYC)     : 1;
    localparam int unsigned IDX_BITS = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    if (NUM_LOCK < 1 || NUM_LOCK > 4) begin : g_chk_num_lock
        $error("fpga_rst_seq: NUM_LOCK must be 1..4");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_chk_sync
        $error("fpga_rst_seq: SYNC_STAGES too small");
    end
    if (STABLE_CYC < 1) begin : g_chk_stable
        $error("fpga_rst_seq: STABLE_CYC must be >= 1");
    end
    if (NUM_DOMAINS < 1) begin : g_chk_domains
        $error("fpga_rst_seq: NUM_DOMAINS must be >= 1");
    end
    if (GAP_CYC < 1) begin : g_chk_gap
        $error("fpga_rst_seq: GAP_CYC must be >= 1");
    end
    if (CNT_W < 1) begin : g_chk_cnt_w
        $error("fpga_rst_seq: CNT_W must be >= 1");
    end

    logic [NUM_LOCK-1:0]    w_lock_sync;
    logic                   w_lock_ok;

    rst_state_t             r_state,   w_state_nxt;
    logic [CNT_BITS-1:0]    r_cnt,     w_cnt_nxt;
    logic [GAP_BITS-1:0]    r_gap,     w_gap_nxt;
    logic [IDX_BITS-1:0]    r_idx,     w_idx_nxt;
    logic [NUM_DOMAINS-1:0] r_srst_n,  w_srst_n_nxt;
    logic                   r_all_rdy, w_all_rdy_nxt;
    logic                   w_loss_inc;
    logic [CNT_W-1:0]       r_loss_cnt;

    for (genvar g = 0; g < NUM_LOCK; g++) begin : g_sync
        fpga_sync_bit #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .arst_n (arst_n),
            .i_d    (lock_i[g]),
            .o_q    (w_lock_sync[g])
        );
    end

    // Masked-out locks count as good.
    assign w_lock_ok = &(w_lock_sync | ~lock_mask);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_idx     <= '0;
            r_srst_n  <= '0;
            r_all_rdy <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gap     <= w_gap_nxt;
            r_idx     <= w_idx_nxt;
            r_srst_n  <= w_srst_n_nxt;
            r_all_rdy <= w_all_rdy_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_gap_nxt     = r_gap;
        w_idx_nxt     = r_idx;
        w_srst_n_nxt  = r_srst_n;
        w_all_rdy_nxt = r_all_rdy;
        w_loss_inc    = 1'b0;

        case (r_state)
            WAIT_LOCK: begin
                if (w_lock_ok && !sw_rst) begin
                    w_state_nxt = QUALIFY;
                    w_cnt_nxt   = '0;
                end
            end

            QUALIFY: begin
                if (!w_lock_ok || sw_rst) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_cnt == CNT_BITS'(STABLE_CYC - 1)) begin
                    w_srst_n_nxt = NUM_DOMAINS'(1);
                    w_idx_nxt    = '0;
                    w_gap_nxt    = '0;
                    if (NUM_DOMAINS == 1) begin
                        w_state_nxt   = RUN;
                        w_all_rdy_nxt = 1'b1;
                    end else begin
                        w_state_nxt = RELEASE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_BITS'(1);
                end
            end

            RELEASE, RUN: begin
                if (!w_lock_ok || sw_rst) begin
                    w_state_nxt   = WAIT_LOCK;
                    w_srst_n_nxt  = '0;
                    w_all_rdy_nxt = 1'b0;
                    w_loss_inc    = !w_lock_ok;
                end else if (r_state == RELEASE) begin
                    if (r_gap == GAP_BITS'(GAP_CYC - 1)) begin
                        // Resets release in bit order, so a thermometer shift suffices.
                        w_gap_nxt    = '0;
                        w_idx_nxt    = r_idx + IDX_BITS'(1);
                        w_srst_n_nxt = (r_srst_n << 1) | NUM_DOMAINS'(1);
                        if (w_idx_nxt == IDX_BITS'(NUM_DOMAINS - 1)) begin
                            w_state_nxt   = RUN;
                            w_all_rdy_nxt = 1'b1;
                        end
                    end else begin
                        w_gap_nxt = r_gap + GAP_BITS'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = WAIT_LOCK;
            end
        endcase
    end

    // Saturating loss counter; a clear coinciding with a loss leaves one loss.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_loss_cnt <= '0;
        end else if (loss_cnt_clr) begin
            r_loss_cnt <= w_loss_inc ? CNT_W'(1) : '0;
        end else if (w_loss_inc && (r_loss_cnt != {CNT_W{1'b1}})) begin
            r_loss_cnt <= r_loss_cnt + CNT_W'(1);
        end
    end

    assign srst_n   = r_srst_n;
    assign all_rdy  = r_all_rdy;
    assign state_o  = r_state;
    assign loss_cnt = r_loss_cnt;

endmodule
